// File: rtl/rx_seq_fifo_if.sv
// rx_seq_fifo_if: byte input, sequence output and status bundle.
// master drives bytes/ready/clear, slave is the FIFO.
interface rx_seq_fifo_if #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int NUM_SEQ = 10
);
  localparam int CW = $clog2(NUM_SEQ + 1);

  logic             valid_in;
  logic [7:0]       byte_in;
  logic             data_end;
  logic             ready_in;
  logic             clr_ovf;
  logic [WIDTH-1:0] array_out [DEPTH-1:0];
  logic             valid_out;
  logic [CW-1:0]    seq_count;
  logic             overflow;

  modport master (
    output valid_in, byte_in, data_end,
    output ready_in, clr_ovf,
    input  array_out, valid_out,
    input  seq_count, overflow
  );

  modport slave (
    input  valid_in, byte_in, data_end,
    input  ready_in, clr_ovf,
    output array_out, valid_out,
    output seq_count, overflow
  );
endinterface

// File: rtl/rx_seq_fifo.sv
// rx_seq_fifo: packs RX bytes into DEPTH x WIDTH sequences, queued in NUM_SEQ slots.
// Macro RX_SEQ_FLUSH_EN: data_end zero-fills and commits a partial sequence.
module rx_seq_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int NUM_SEQ   = 10,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  rx_seq_fifo_if.slave bus
);
  localparam int BPW = WIDTH / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW  = $clog2(NUM_SEQ);
  localparam int CW  = $clog2(NUM_SEQ + 1);

  localparam logic [BIW-1:0] BLAST = BIW'(BPW - 1);
  localparam logic [WIW-1:0] WLAST = WIW'(DEPTH - 1);
  localparam logic [PW-1:0]  PLAST = PW'(NUM_SEQ - 1);
  localparam logic [CW-1:0]  CFULL = CW'(NUM_SEQ);

  logic [BIW-1:0]   byte_idx_q, byte_idx_d;
  logic [WIW-1:0]   word_idx_q, word_idx_d;
  logic [WIDTH-1:0] asm_q [DEPTH];
  logic [WIDTH-1:0] asm_d [DEPTH];
  logic [WIDTH-1:0] slot_q [NUM_SEQ][DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [BIW-1:0] lane;
  logic           last_byte;
  logic           partial;
  logic           restart;
  logic           commit;
  logic           can_push;
  logic           push;
  logic           pop;

  assign last_byte = bus.valid_in
                   & (byte_idx_q == BLAST)
                   & (word_idx_q == WLAST);

  assign partial = bus.valid_in ? ~last_byte
                 : ((byte_idx_q != '0) | (word_idx_q != '0));

  assign restart = last_byte | (bus.data_end & partial);

`ifdef RX_SEQ_FLUSH_EN
  assign commit = restart;
`else
  assign commit = last_byte;
`endif

  assign pop      = (count_q != '0) & bus.ready_in;
  assign can_push = (count_q != CFULL) | pop;
  assign push     = commit & can_push;

  // Merge the incoming byte into the assembly and advance lane/word indices.
  always_comb begin
    asm_d      = asm_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    lane       = LSB_FIRST ? byte_idx_q : BLAST - byte_idx_q;
    if (bus.valid_in) begin
      asm_d[word_idx_q][{lane, 3'b000} +: 8] = bus.byte_in;
    end
    if (restart) begin
      byte_idx_d = '0;
      word_idx_d = '0;
    end else if (bus.valid_in) begin
      if (byte_idx_q == BLAST) begin
        byte_idx_d = '0;
        word_idx_d = word_idx_q + 1'b1;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end
  end

  // Queue pointers, occupancy and sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PLAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PLAST) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (commit & ~can_push) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Control state; assembly is zeroed on restart so a flush reads zero fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q <= '0;
      word_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) asm_q[i] <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      for (int i = 0; i < DEPTH; i++) begin
        asm_q[i] <= restart ? '0 : asm_d[i];
      end
    end
  end

  // Slot storage needs no reset: unread until count says it is occupied.
  always_ff @(posedge clk) begin
    if (push) slot_q[wr_ptr_q] <= asm_d;
  end

  // Head slot, forced to zero while the queue is empty.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      bus.array_out[i] = (count_q != '0) ? slot_q[rd_ptr_q][i] : '0;
    end
  end

  assign bus.valid_out = (count_q != '0);
  assign bus.seq_count = count_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_rx_seq_fifo.sv
// tb_rx_seq_fifo: random and directed stimulus on two FIFOs (both byte orders),
// scoreboard of committed byte sequences drained by a negedge monitor.
module tb_rx_seq_fifo;
  localparam int W   = 32;
  localparam int D   = 8;
  localparam int N   = 10;
  localparam int BPW = W / 8;
  localparam int SB  = D * BPW;

  typedef logic [7:0] seq_t [SB];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       data_end = 1'b0;
  logic       ready_in = 1'b0;
  logic       clr_ovf = 1'b0;

  rx_seq_fifo_if #(.WIDTH(W), .DEPTH(D), .NUM_SEQ(N)) if_lsb ();
  rx_seq_fifo_if #(.WIDTH(W), .DEPTH(D), .NUM_SEQ(N)) if_msb ();

  assign if_lsb.valid_in = valid_in;
  assign if_lsb.byte_in  = byte_in;
  assign if_lsb.data_end = data_end;
  assign if_lsb.ready_in = ready_in;
  assign if_lsb.clr_ovf  = clr_ovf;
  assign if_msb.valid_in = valid_in;
  assign if_msb.byte_in  = byte_in;
  assign if_msb.data_end = data_end;
  assign if_msb.ready_in = ready_in;
  assign if_msb.clr_ovf  = clr_ovf;

  rx_seq_fifo #(
    .WIDTH(W), .DEPTH(D), .NUM_SEQ(N), .LSB_FIRST(1'b1)
  ) u_lsb (
    .clk(clk), .rst_n(rst_n), .bus(if_lsb.slave)
  );

  rx_seq_fifo #(
    .WIDTH(W), .DEPTH(D), .NUM_SEQ(N), .LSB_FIRST(1'b0)
  ) u_msb (
    .clk(clk), .rst_n(rst_n), .bus(if_msb.slave)
  );

  always #5 clk = ~clk;

  seq_t       sb [$];
  logic [7:0] part [$];
  bit         exp_ovf = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         done = 1'b0;

  function automatic logic [W-1:0] exp_word(input seq_t s, input int w,
                                            input bit lsb);
    logic [W-1:0] r;
    int lane;
    r = '0;
    for (int b = 0; b < BPW; b++) begin
      lane = lsb ? b : BPW - 1 - b;
      r[lane*8 +: 8] = s[w*BPW + b];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; model decides the commit outcome from the rules.
  task automatic step(input bit v, input logic [7:0] b, input bit de,
                      input bit rdy, input bit clr);
    bit   have;
    bit   push;
    bit   drop;
    seq_t s;
    valid_in = v;
    byte_in  = b;
    data_end = de;
    ready_in = rdy;
    clr_ovf  = clr;
    have = 0;
    push = 0;
    drop = 0;
    for (int i = 0; i < SB; i++) s[i] = 8'h00;
    if (v) begin
      part.push_back(b);
      if (part.size() == SB) begin
        for (int i = 0; i < SB; i++) s[i] = part[i];
        part.delete();
        have = 1;
      end
    end
    if (de && part.size() != 0) begin
`ifdef RX_SEQ_FLUSH_EN
      for (int i = 0; i < part.size(); i++) s[i] = part[i];
      have = 1;
`endif
      part.delete();
    end
    if (have) begin
      if (sb.size() < N || (sb.size() != 0 && rdy)) push = 1;
      else drop = 1;
    end
    @(posedge clk);
    #1;
    if (push) sb.push_back(s);
    if (drop) exp_ovf = 1;
    else if (clr) exp_ovf = 0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, rdy, 0);
  endtask

  task automatic rand_bytes(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1, 8'($urandom), 0, rdy, 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_valid"}, 32'(if_lsb.valid_out), 0);
    chk({nm, "_count"}, 32'(if_lsb.seq_count), 0);
    chk({nm, "_ovf"}, 32'(if_lsb.overflow), 0);
    chk({nm, "_valid_m"}, 32'(if_msb.valid_out), 0);
    for (int w = 0; w < D; w++) begin
      chk({nm, "_arr"}, if_lsb.array_out[w], 0);
      chk({nm, "_arr_m"}, if_msb.array_out[w], 0);
    end
  endtask

  task automatic do_reset();
    valid_in = 0;
    data_end = 0;
    ready_in = 0;
    clr_ovf  = 0;
    rst_n    = 0;
    #1;
    chk_reset_outputs("rst");
    sb.delete();
    part.delete();
    exp_ovf = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // Monitor: status every cycle, head against scoreboard, pop on handshake.
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    logic [W-1:0] bg;
    logic [W-1:0] be;
    int           bw;
    bit           bad;
    if (!done) begin
      chk("valid_out", 32'(if_lsb.valid_out), 32'(sb.size() != 0));
      chk("valid_out_m", 32'(if_msb.valid_out), 32'(sb.size() != 0));
      chk("seq_count", 32'(if_lsb.seq_count), sb.size());
      chk("seq_count_m", 32'(if_msb.seq_count), sb.size());
      chk("overflow", 32'(if_lsb.overflow), 32'(exp_ovf));
      chk("overflow_m", 32'(if_msb.overflow), 32'(exp_ovf));
      if (sb.size() != 0) begin
        for (int k = 0; k < 2; k++) begin
          bad = 0;
          bw  = 0;
          bg  = '0;
          be  = '0;
          for (int w = 0; w < D; w++) begin
            got = (k == 0) ? if_lsb.array_out[w] : if_msb.array_out[w];
            exp = exp_word(sb[0], w, k == 0);
            if (got !== exp && !bad) begin
              bad = 1;
              bw  = w;
              bg  = got;
              be  = exp;
            end
          end
          n_chk++;
          if (bad) begin
            n_fail++;
            $display("FAIL head_%s word%0d: got %h expected %h at %0t",
                     (k == 0) ? "lsb" : "msb", bw, bg, be, $time);
          end
        end
        if (ready_in && rst_n) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1;
    chk_reset_outputs("init");
    @(posedge clk);
    #1;
    rst_n = 1;

    for (int i = 0; i < SB; i++) step(1, 8'(i), 0, 0, 0);
    chk("dir_lsb_w0", if_lsb.array_out[0], 32'h03020100);
    chk("dir_lsb_w7", if_lsb.array_out[7], 32'h1F1E1D1C);
    chk("dir_msb_w0", if_msb.array_out[0], 32'h00010203);
    idle(1, 0);
    idle(2, 1);

    for (int s = 0; s < N + 1; s++) rand_bytes(SB, 0);
    idle(1, 0);
    step(0, 8'h00, 0, 0, 1);
    idle(1, 0);

    rand_bytes(SB - 1, 0);
    step(1, 8'($urandom), 0, 1, 0);
    idle(N + 2, 1);

    for (int i = 0; i < 5; i++) step(1, 8'(8'hA1 + i), 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    idle(1, 0);
    rand_bytes(SB, 0);
    idle(3, 1);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), 8'($urandom),
           ($urandom_range(0, 99) < 2), $urandom_range(0, 1),
           ($urandom_range(0, 99) < 3));
    end
    idle(N + 2, 1);

    for (int s = 0; s < 3; s++) rand_bytes(SB, 0);
    rand_bytes(10, 0);
    do_reset();
    rand_bytes(SB, 0);
    idle(1, 0);
    idle(3, 1);

    idle(N + 2, 1);
    chk("final_count", 32'(if_lsb.seq_count), 0);
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
